krv_avalon_mm_bridge: RTL

Parametrised bridge between one KyogenRV CPU memory port (imem or dmem) and a pipelined

---
 rtl/krv_bridge_pkg.sv | 27 ++
 rtl/krv_sync_fifo.sv | 61 ++++++
 rtl/krv_avalon_mm_bridge.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/krv_bridge_pkg.sv
// Shared types and helpers for the KyogenRV CPU-to-Avalon-MM bridge.
package krv_bridge_pkg;

  // Native KyogenRV memory port widths.
  localparam int KRV_ADDR_W = 32;
  localparam int KRV_DATA_W = 32;
  localparam int KRV_BE_W   = KRV_DATA_W / 8;

  // One CPU command as seen at a KyogenRV-width memory port.
  typedef struct packed {
    logic                  write;
    logic [KRV_ADDR_W-1:0] addr;
    logic [KRV_DATA_W-1:0] wdata;
    logic [KRV_BE_W-1:0]   be;
  } cmd_t;

  // Command slot states, kept as plain constants for older tool flows.
  typedef logic [0:0] state_e;
  localparam state_e IDLE  = 1'b0;
  localparam state_e ISSUE = 1'b1;

  // Bits needed to index/count 'value' distinct values, never below one bit.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/krv_sync_fifo.sv
// Small synchronous FIFO with occupancy count; buffers Avalon read responses in order.
module krv_sync_fifo
  import krv_bridge_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int CNT_W = clog2_min1(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int              PTR_W      = clog2_min1(DEPTH);
  localparam logic [PTR_W-1:0] LAST_SLOT  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == FULL_COUNT);
  assign do_pop   = pop & !empty;
  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign do_push  = push & (!full | do_pop);
  assign pop_data = mem[rd_ptr];

  // Storage write.
  // NOTE: the array has no reset; count says which entries are valid, so it can map to plain RAM.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == LAST_SLOT) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/krv_avalon_mm_bridge.sv
// Bridge from one KyogenRV memory port to a pipelined Avalon-MM master: single command slot,
// credit-limited outstanding reads, in-order response buffer, CPU stall and post-reset halt.
module krv_avalon_mm_bridge
  import krv_bridge_pkg::*;
#(
  parameter  int ADDR_W      = 32,
  parameter  int DATA_W      = 32,
  parameter  int MAX_PENDING = 4,
  parameter  int HALT_CYCLES = 1,
  localparam int BE_W        = DATA_W / 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_cmd_valid,
  output logic              cpu_cmd_ready,
  input  logic              cpu_cmd_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [BE_W-1:0]   cpu_be,
  output logic              cpu_rd_valid,
  output logic [DATA_W-1:0] cpu_rd_data,
  input  logic              cpu_rd_ready,
  output logic              cpu_wr_done,
  output logic              cpu_halt,
  output logic              cpu_stall,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  output logic [BE_W-1:0]   avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  output logic              resp_err
);

  localparam int               CRED_W    = clog2_min1(MAX_PENDING + 1);
  localparam int               HALT_W    = clog2_min1(HALT_CYCLES + 1);
  localparam logic [CRED_W-1:0] CRED_MAX  = CRED_W'(MAX_PENDING);
  localparam logic [HALT_W-1:0] HALT_LOAD = HALT_W'(HALT_CYCLES);

  // Command held on the Avalon side while the slave stalls.
  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } slot_t;

  logic [HALT_W-1:0] halt_cnt;
  state_e            state;
  slot_t             slot;
  logic [CRED_W-1:0] credits;
  logic [CRED_W-1:0] fifo_count;
  logic [CRED_W-1:0] unanswered;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              slot_free;
  logic              accept;
  logic              rd_pop;
  logic              rd_push;
  logic              stray_rsp;

  assign cpu_halt  = (halt_cnt != '0);
  // The slot can take a new command when empty or when its current one leaves this cycle.
  assign slot_free = (state == IDLE) | !avm_waitrequest;
  assign cpu_cmd_ready = !cpu_halt & slot_free & (cpu_cmd_write | (credits < CRED_MAX));
  assign accept    = cpu_cmd_valid & cpu_cmd_ready;
  assign cpu_stall = cpu_cmd_valid & !cpu_cmd_ready;

  assign avm_read       = (state == ISSUE) & !slot.write;
  assign avm_write      = (state == ISSUE) & slot.write;
  assign avm_address    = slot.addr;
  assign avm_writedata  = slot.wdata;
  assign avm_byteenable = slot.be;
  assign cpu_wr_done    = avm_write & !avm_waitrequest;

  assign rd_pop       = cpu_rd_ready & !fifo_empty;
  assign cpu_rd_valid = !fifo_empty;
  assign cpu_rd_data  = fifo_empty ? '0 : fifo_head;

  // Credited reads that are neither buffered nor still waiting in the slot are on the bus.
  assign unanswered = credits - fifo_count - CRED_W'(avm_read);
  assign stray_rsp  = avm_readdatavalid & (unanswered == '0);
  // The full term cannot trigger while credits are honoured; it only protects the buffer.
  assign rd_push    = avm_readdatavalid & !stray_rsp & (!fifo_full | rd_pop);

  // Post-reset halt window: count down from HALT_CYCLES once reset releases.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)         halt_cnt <= HALT_LOAD;
    else if (cpu_halt) halt_cnt <= halt_cnt - 1'b1;
  end

  // Command slot: capture on accept, hold until the slave drops waitrequest.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      slot  <= '0;
    end else if (accept) begin
      state <= ISSUE;
      slot  <= '{write: cpu_cmd_write,
                 addr:  cpu_addr,
                 wdata: cpu_wdata,
                 be:    cpu_cmd_write ? cpu_be : '1};
    end else if ((state == ISSUE) && !avm_waitrequest) begin
      state <= IDLE;
    end
  end

  // Read credits: taken when a read enters the slot, returned when the CPU pops its data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      credits <= '0;
    end else begin
      case ({accept & !cpu_cmd_write, rd_pop})
        2'b10:   credits <= credits + 1'b1;
        2'b01:   credits <= credits - 1'b1;
        default: credits <= credits;
      endcase
    end
  end

  // Sticky flag for a response nobody asked for.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)          resp_err <= 1'b0;
    else if (stray_rsp) resp_err <= 1'b1;
  end

  krv_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (MAX_PENDING)
  ) u_rsp_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (rd_push),
    .push_data (avm_readdata),
    .pop       (rd_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule
